// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch front end. It owns the program counter and runs a
// request/acknowledge handshake with instruction memory. It buffers one
// fetched instruction, presenting it as (pc, pc+4, instruction) to the IF/ID
// register. It holds that instruction across stalls, and drops wrong-path
// fetches after a branch redirect. While nothing valid is buffered, it
// presents a NOP so that IF/ID captures a bubble.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   ifid_write        IF/ID capture enable; buffered outputs are consumed when high
//   branch_taken      single-cycle redirect pulse from EX
//   branch_target     redirect address (low two bits ignored)
//   imem_req          memory request, held with a stable imem_addr until ack
//   imem_addr         memory request address
//   imem_ack          one-cycle acknowledge, imem_rdata valid in the same cycle
//   imem_rdata        fetched instruction word
//   if_pc             PC of the buffered instruction
//   if_pc_plus_4      if_pc + 4 (wraps modulo 2^32)
//   if_instruction    buffered instruction, or NOP_INSTR when if_valid is low
//   if_valid          buffer holds a correct-path instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifid_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  // S_REQ : a correct-path request is outstanding
  // S_FULL: the buffer holds a valid instruction, no request is outstanding
  // S_DROP: a wrong-path request is outstanding; its data will be discarded
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] target;

  assign target = branch_target & ~32'h3;

  // Outside S_DROP, pc_q is the address that follows the request in
  // req_addr_q. In S_DROP, req_addr_q must stay frozen on the wrong-path
  // address until memory acknowledges it. During that time, pc_q holds the
  // redirect target itself, which becomes the next request.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    case (state_q)
      S_REQ: begin
        if (branch_taken) begin
          if (imem_ack) begin
            req_addr_d = target;
            pc_d       = target + 32'd4;
          end else begin
            pc_d    = target;
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          buf_instr_d = imem_rdata;
          buf_pc_d    = req_addr_q;
          state_d     = S_FULL;
        end
      end
      S_FULL: begin
        // A redirect flushes the buffer even if IF/ID is capturing this edge.
        if (branch_taken) begin
          req_addr_d = target;
          pc_d       = target + 32'd4;
          state_d    = S_REQ;
        end else if (ifid_write) begin
          req_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          if (branch_taken) begin
            req_addr_d = target;
            pc_d       = target + 32'd4;
          end else begin
            req_addr_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end
          state_d = S_REQ;
        end else if (branch_taken) begin
          pc_d = target;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and datapath registers, all cleared immediately on reset so that
  // an in-flight transaction is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC + 32'd4;
      req_addr_q  <= RESET_PC;
      buf_pc_q    <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign imem_req       = (state_q != S_FULL);
  assign imem_addr      = req_addr_q;
  assign if_valid       = (state_q == S_FULL);
  assign if_instruction = if_valid ? buf_instr_q : NOP_INSTR;
  assign if_pc          = buf_pc_q;
  assign if_pc_plus_4   = buf_pc_q + 32'd4;

endmodule
